// File: rtl/pcs_block_lock_if.sv
// Bus between the PMA/gearbox side and the block-lock monitor.
// The receive path drives the header bus; the monitor returns lock, slip and BER status.
interface pcs_block_lock_if #(
  parameter int ERR_W = 16
);
  logic [1:0]       hdr;
  logic             hdr_vld;
  logic             clr_cnt;
  logic             pma_slip;
  logic             pma_sync;
  logic             hi_ber;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output hdr, hdr_vld, clr_cnt,
    input  pma_slip, pma_sync, hi_ber, err_cnt
  );

  modport slave (
    input  hdr, hdr_vld, clr_cnt,
    output pma_slip, pma_sync, hi_ber, err_cnt
  );
endinterface

// File: rtl/pcs_block_lock.sv
// 10GBASE-R receive block lock: hunts sync-header alignment with PMA slips,
// tracks lock quality over header windows and flags high BER over a timed window.
module pcs_block_lock #(
  parameter int LOCK_CNT  = 64,
  parameter int WIN_CNT   = 64,
  parameter int BAD_MAX   = 16,
  parameter int SLIP_WAIT = 32,
  parameter int BER_TIMER = 19531,
  parameter int BER_MAX   = 16,
  parameter int ERR_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pcs_block_lock_if.slave bus
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int TMR_W  = $clog2(BER_TIMER + 1);
  localparam int BER_W  = $clog2(BER_MAX + 1);
  localparam logic [BER_W-1:0] BER_TOP = BER_W'(BER_MAX);

  typedef enum logic [1:0] {HUNT, SLIP, LOCKED} state_t;

  state_t state, state_nxt;

  logic [SH_W-1:0]   sh_cnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMR_W-1:0]  timer;
  logic [BER_W-1:0]  ber_cnt;
  logic [ERR_W-1:0]  err_q;
  logic              slip_q, sync_q, hi_ber_q;
  logic              slip_d, sync_d;

  logic hdr_ok, good, bad;
  logic sh_done, bad_hit, win_end, wait_done, ber_wrap;

  assign hdr_ok    = bus.hdr[1] ^ bus.hdr[0];
  assign good      = bus.hdr_vld & hdr_ok;
  assign bad       = bus.hdr_vld & ~hdr_ok;
  assign sh_done   = good && (sh_cnt == SH_W'(LOCK_CNT - 1));
  assign bad_hit   = bad && (bad_cnt == BAD_W'(BAD_MAX - 1));
  assign win_end   = bus.hdr_vld && (win_cnt == WIN_W'(WIN_CNT - 1));
  assign wait_done = (wait_cnt == WAIT_W'(SLIP_WAIT - 1));
  assign ber_wrap  = (timer == TMR_W'(BER_TIMER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      slip_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      slip_q <= slip_d;
      sync_q <= sync_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      HUNT:    if (bad) state_nxt = SLIP;
               else if (sh_done) state_nxt = LOCKED;
      SLIP:    if (wait_done) state_nxt = HUNT;
      LOCKED:  if (bad_hit) state_nxt = SLIP;
      default: state_nxt = HUNT;
    endcase
  end

  // Outputs are registered from the next state so decisions show one clk after the header.
  always_comb begin
    slip_d = (state_nxt == SLIP) && (state != SLIP);
    sync_d = (state_nxt == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_cnt   <= '0;
      win_cnt  <= '0;
      bad_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      unique case (state)
        HUNT: begin
          wait_cnt <= '0;
          win_cnt  <= '0;
          bad_cnt  <= '0;
          if (bad || sh_done) sh_cnt <= '0;
          else if (good)      sh_cnt <= sh_cnt + 1'b1;
        end
        SLIP: begin
          sh_cnt   <= '0;
          wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
        end
        LOCKED: begin
          if (bus.hdr_vld) begin
            if (bad_hit || win_end) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              bad_cnt <= bad_cnt + BAD_W'(bad);
            end
          end
        end
        default: begin
          sh_cnt   <= '0;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err_q <= '0;
    else if (bus.clr_cnt)                               err_q <= '0;
    else if ((state == LOCKED) && bad && (err_q != '1)) err_q <= err_q + 1'b1;
  end

  // A bad header on the wrap cycle belongs to the new window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else if (!sync_q) begin
      timer    <= '0;
      ber_cnt  <= '0;
      hi_ber_q <= 1'b0;
    end else if (ber_wrap) begin
      timer    <= '0;
      ber_cnt  <= BER_W'(bad);
      hi_ber_q <= (ber_cnt == BER_TOP) || (BER_W'(bad) == BER_TOP);
    end else begin
      timer <= timer + 1'b1;
      if (bad && (ber_cnt != BER_TOP)) begin
        ber_cnt <= ber_cnt + 1'b1;
        if (ber_cnt == BER_TOP - 1'b1) hi_ber_q <= 1'b1;
      end
    end
  end

  assign bus.pma_slip = slip_q;
  assign bus.pma_sync = sync_q;
  assign bus.hi_ber   = hi_ber_q;
  assign bus.err_cnt  = err_q;

endmodule
